// File: rtl/deser_frame_unpacker_pkg.sv
// ---------------------------------------------------------------------------
// deser_frame_unpacker_pkg
// Shared types and width helpers for the deserializer-side blocks.
//   unpack_state_t : unpacker FSM states (S_IDLE, S_DRAIN)
//   SAMPLE_IDX_W   : width of a sample index for the default frame depth
//   BIT_IDX_W      : width of a bit index for the default sample width
//   idx_w()        : index width for an arbitrary count (inclusive max index
//                    plus one spare bit, matching the deserializer ports)
// ---------------------------------------------------------------------------
package deser_frame_unpacker_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } unpack_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DATA_DEPTH = 4;

    localparam int SAMPLE_IDX_W = $clog2(DEF_DATA_DEPTH) + 1;
    localparam int BIT_IDX_W    = $clog2(DEF_DATA_WIDTH) + 1;

    function automatic int idx_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/deser_frame_unpacker_width_mask_gen.sv
// ---------------------------------------------------------------------------
// deser_frame_unpacker_width_mask_gen
// Combinational conversion of a "last valid bit" index into a sample mask.
//   i_width : index of the highest valid bit (width minus 1, inclusive)
//   o_mask  : bits 0..i_width set; all ones when i_width >= DATA_WIDTH-1
// ---------------------------------------------------------------------------
module deser_frame_unpacker_width_mask_gen
    import deser_frame_unpacker_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int BIDX_W     = idx_w(DATA_WIDTH)
) (
    input  logic [BIDX_W-1:0]     i_width,
    output logic [DATA_WIDTH-1:0] o_mask
);

    // The index port carries one spare bit, so values past the top sample
    // bit are possible; those saturate to a full-width mask.
    logic w_sat;
    assign w_sat = (i_width >= BIDX_W'(DATA_WIDTH - 1));

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask_bit
            assign o_mask[gi] = w_sat | (i_width >= BIDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/deser_frame_unpacker.sv
// ---------------------------------------------------------------------------
// deser_frame_unpacker
// Captures a whole frame from the deserializer on its done pulse and replays
// it one sample per beat on a valid/ready stream.
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_des_done       : deserializer done pulse (frame valid same cycle)
//   i_des_par_out    : frame, sample k = i_des_par_out[k]
//   i_des_width      : index of the last valid bit of each sample
//   i_des_depth      : index of the last valid sample (clamped to DEPTH-1)
//   o_m_valid/i_m_ready/o_m_data/o_m_last/o_m_index : output stream
//   o_busy           : a frame is held / draining
//   o_overflow       : sticky, a frame arrived while draining and was dropped
//   i_clr_overflow   : synchronous clear of o_overflow (a new drop wins)
// ---------------------------------------------------------------------------
module deser_frame_unpacker
    import deser_frame_unpacker_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DATA_DEPTH = 4,
    localparam int SIDX_W     = idx_w(DATA_DEPTH),
    localparam int BIDX_W     = idx_w(DATA_WIDTH)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_des_done,
    input  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] i_des_par_out,
    input  logic [BIDX_W-1:0]                    i_des_width,
    input  logic [SIDX_W-1:0]                    i_des_depth,
    output logic                                 o_m_valid,
    input  logic                                 i_m_ready,
    output logic [DATA_WIDTH-1:0]                o_m_data,
    output logic                                 o_m_last,
    output logic [SIDX_W-1:0]                    o_m_index,
    output logic                                 o_busy,
    output logic                                 o_overflow,
    input  logic                                 i_clr_overflow
);

    localparam int                RD_W    = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [SIDX_W-1:0] MAX_IDX = SIDX_W'(DATA_DEPTH - 1);

    unpack_state_t         r_state;
    unpack_state_t         w_state_next;
    logic                  r_done_q;
    logic [DATA_WIDTH-1:0] r_frame [DATA_DEPTH];
    logic [SIDX_W-1:0]     r_depth;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [SIDX_W-1:0]     r_idx;
    logic                  r_overflow;

    logic                  w_drain;
    logic                  w_cap;
    logic                  w_hs;
    logic                  w_last;
    logic                  w_load;
    logic                  w_ovf_set;
    logic [SIDX_W-1:0]     w_depth_clamped;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [RD_W-1:0]       w_rd_idx;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign w_drain = (r_state == S_DRAIN);

    // Rising edge of done: a done held high for several cycles is one frame.
    assign w_cap  = i_des_done & ~r_done_q;
    assign w_hs   = w_drain & i_m_ready;
    assign w_last = (r_idx == r_depth);

    // Load from IDLE, or chain straight into the next frame when the new
    // frame lands on the same cycle as the final handshake (no bubble).
    assign w_load = w_cap & (~w_drain | (w_hs & w_last));

    // Any other capture while draining is lost.
    assign w_ovf_set = w_cap & w_drain & ~(w_hs & w_last);

    assign w_depth_clamped = (i_des_depth > MAX_IDX) ? MAX_IDX : i_des_depth;

    // idx never exceeds r_depth <= DATA_DEPTH-1, so the low bits address
    // the frame buffer directly.
    assign w_rd_idx = r_idx[RD_W-1:0];

    deser_frame_unpacker_width_mask_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_width_mask_gen (
        .i_width (i_des_width),
        .o_mask  (w_mask)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cap) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_hs && w_last && !w_cap) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (registers only, no input-to-output path)
    // ------------------------------------------------------------------
    always_comb begin
        o_m_valid = 1'b0;
        o_busy    = 1'b0;
        o_m_data  = '0;
        o_m_last  = 1'b0;
        case (r_state)
            S_DRAIN: begin
                o_m_valid = 1'b1;
                o_busy    = 1'b1;
                o_m_data  = r_frame[w_rd_idx] & r_mask;
                o_m_last  = w_last;
            end
            default: begin
            end
        endcase
    end

    assign o_m_index  = r_idx;
    assign o_overflow = r_overflow;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_q <= 1'b0;
        end else begin
            r_done_q <= i_des_done;
        end
    end

    generate
        for (genvar gi = 0; gi < DATA_DEPTH; gi++) begin : g_frame
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_frame[gi] <= '0;
                end else if (w_load) begin
                    r_frame[gi] <= i_des_par_out[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth <= '0;
            r_mask  <= '0;
        end else if (w_load) begin
            r_depth <= w_depth_clamped;
            r_mask  <= w_mask;
        end
    end

    // idx returns to 0 after the final beat so an idle block shows index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_load) begin
            r_idx <= '0;
        end else if (w_hs) begin
            r_idx <= w_last ? '0 : (r_idx + SIDX_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (i_clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_deser_frame_unpacker.sv
// ---------------------------------------------------------------------------
// tb_deser_frame_unpacker
// Directed bench for deser_frame_unpacker: basic drain, width mask, depth
// clamp, backpressure, overflow, back-to-back capture and mid-drain reset.
// ---------------------------------------------------------------------------
module tb_deser_frame_unpacker;

    localparam int DW = 32;
    localparam int DD = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  des_done = 1'b0;
    logic [DD-1:0][DW-1:0] des_par_out = '0;
    logic [5:0]            des_width = '0;
    logic [2:0]            des_depth = '0;
    logic                  m_valid;
    logic                  m_ready = 1'b1;
    logic [DW-1:0]         m_data;
    logic                  m_last;
    logic [2:0]            m_index;
    logic                  busy;
    logic                  overflow;
    logic                  clr_overflow = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    deser_frame_unpacker #(
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_des_done     (des_done),
        .i_des_par_out  (des_par_out),
        .i_des_width    (des_width),
        .i_des_depth    (des_depth),
        .o_m_valid      (m_valid),
        .i_m_ready      (m_ready),
        .o_m_data       (m_data),
        .o_m_last       (m_last),
        .o_m_index      (m_index),
        .o_busy         (busy),
        .o_overflow     (overflow),
        .i_clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] s0, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [31:0] s3,
                        input logic [5:0] w, input logic [2:0] d);
        des_par_out[0] = s0;
        des_par_out[1] = s1;
        des_par_out[2] = s2;
        des_par_out[3] = s3;
        des_width      = w;
        des_depth      = d;
    endtask

    task automatic pulse_done();
        des_done = 1'b1;
        tick();
        des_done = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input int idx, input logic last);
        $display("[TB] %s: valid=%b data=%h index=%0d last=%b", tag, m_valid, m_data, m_index, m_last);
        chk({tag, ".valid"}, 32'(m_valid), 32'd1);
        chk({tag, ".data"},  m_data, d);
        chk({tag, ".index"}, 32'(m_index), 32'(idx));
        chk({tag, ".last"},  32'(m_last), 32'(last));
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst.valid",    32'(m_valid),  32'd0);
        chk("rst.data",     m_data,        32'd0);
        chk("rst.last",     32'(m_last),   32'd0);
        chk("rst.index",    32'(m_index),  32'd0);
        chk("rst.busy",     32'(busy),     32'd0);
        chk("rst.overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle.valid", 32'(m_valid), 32'd0);

        // ---------------- basic drain ----------------
        load(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 6'd31, 3'd3);
        m_ready = 1'b1;
        pulse_done();
        for (int k = 0; k < 4; k++) begin
            beat("basic", 32'(32'h11111111 * (k + 1)), k, (k == 3));
            chk("basic.busy", 32'(busy), 32'd1);
            tick();
        end
        chk("basic.end_valid", 32'(m_valid), 32'd0);
        chk("basic.end_busy",  32'(busy),    32'd0);

        // ---------------- width mask + depth ----------------
        load(32'hDEADBEEF, 32'hCAFEF00D, 32'h99999999, 32'h99999999, 6'd7, 3'd1);
        pulse_done();
        beat("mask0", 32'h000000EF, 0, 1'b0);
        tick();
        beat("mask1", 32'h0000000D, 1, 1'b1);
        tick();
        chk("mask.end_valid", 32'(m_valid), 32'd0);

        // ---------------- backpressure ----------------
        load(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 6'd31, 3'd3);
        pulse_done();
        beat("bp0", 32'h11111111, 0, 1'b0);
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat("bp_stall", 32'h22222222, 1, 1'b0);
            tick();
        end
        m_ready = 1'b1;
        beat("bp1", 32'h22222222, 1, 1'b0);
        tick();
        beat("bp2", 32'h33333333, 2, 1'b0);
        tick();
        beat("bp3", 32'h44444444, 3, 1'b1);
        tick();
        chk("bp.end_valid", 32'(m_valid), 32'd0);

        // ---------------- overflow ----------------
        chk("ovf.pre", 32'(overflow), 32'd0);
        pulse_done();
        beat("ovf0", 32'h11111111, 0, 1'b0);
        tick();
        beat("ovf1", 32'h22222222, 1, 1'b0);
        load(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 6'd31, 3'd3);
        des_done = 1'b1;
        tick();
        des_done = 1'b0;
        chk("ovf.set", 32'(overflow), 32'd1);
        beat("ovf2", 32'h33333333, 2, 1'b0);
        tick();
        beat("ovf3", 32'h44444444, 3, 1'b1);
        tick();
        chk("ovf.dropped_valid", 32'(m_valid), 32'd0);
        chk("ovf.sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf.clear", 32'(overflow), 32'd0);

        // coincident set and clear: set wins
        load(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 6'd31, 3'd3);
        pulse_done();
        beat("ovfc0", 32'h11111111, 0, 1'b0);
        tick();
        des_done     = 1'b1;
        clr_overflow = 1'b1;
        tick();
        des_done     = 1'b0;
        clr_overflow = 1'b0;
        chk("ovf.set_wins", 32'(overflow), 32'd1);
        beat("ovfc2", 32'h33333333, 2, 1'b0);
        tick();
        beat("ovfc3", 32'h44444444, 3, 1'b1);
        tick();
        chk("ovfc.end_valid", 32'(m_valid), 32'd0);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovfc.clear", 32'(overflow), 32'd0);

        // ---------------- back-to-back ----------------
        load(32'h11111111, 32'h22222222, 32'h0, 32'h0, 6'd31, 3'd1);
        pulse_done();
        beat("b2b_a0", 32'h11111111, 0, 1'b0);
        tick();
        beat("b2b_a1", 32'h22222222, 1, 1'b1);
        load(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 6'd31, 3'd3);
        des_done = 1'b1;
        tick();
        des_done = 1'b0;
        beat("b2b_b0", 32'hAAAAAAAA, 0, 1'b0);
        tick();
        beat("b2b_b1", 32'hBBBBBBBB, 1, 1'b0);
        tick();
        beat("b2b_b2", 32'hCCCCCCCC, 2, 1'b0);
        tick();
        beat("b2b_b3", 32'hDDDDDDDD, 3, 1'b1);
        tick();
        chk("b2b.end_valid", 32'(m_valid),  32'd0);
        chk("b2b.no_ovf",    32'(overflow), 32'd0);

        // done held high three cycles: one frame only
        load(32'h11111111, 32'h22222222, 32'h0, 32'h0, 6'd31, 3'd1);
        des_done = 1'b1;
        tick();
        beat("held0", 32'h11111111, 0, 1'b0);
        tick();
        beat("held1", 32'h22222222, 1, 1'b1);
        tick();
        des_done = 1'b0;
        chk("held.valid_a", 32'(m_valid), 32'd0);
        tick();
        chk("held.valid_b", 32'(m_valid),  32'd0);
        chk("held.no_ovf",  32'(overflow), 32'd0);

        // ---------------- reset mid-drain ----------------
        load(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 6'd31, 3'd3);
        pulse_done();
        beat("rstd0", 32'h11111111, 0, 1'b0);
        tick();
        beat("rstd1", 32'h22222222, 1, 1'b0);
        des_done = 1'b1;
        tick();
        des_done = 1'b0;
        chk("rstd.ovf_before", 32'(overflow), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstd.valid",    32'(m_valid),  32'd0);
        chk("rstd.data",     m_data,        32'd0);
        chk("rstd.last",     32'(m_last),   32'd0);
        chk("rstd.index",    32'(m_index),  32'd0);
        chk("rstd.busy",     32'(busy),     32'd0);
        chk("rstd.overflow", 32'(overflow), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstd.post_valid_a", 32'(m_valid), 32'd0);
        tick();
        tick();
        chk("rstd.post_valid_b", 32'(m_valid), 32'd0);
        chk("rstd.post_index",   32'(m_index), 32'd0);

        // ---------------- depth clamp ----------------
        load(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 6'd31, 3'd7);
        pulse_done();
        for (int k = 0; k < 4; k++) begin
            beat("clamp", 32'(32'h11111111 * (k + 1)), k, (k == 3));
            tick();
        end
        chk("clamp.end_valid", 32'(m_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/deser_frame_unpacker.md
Name: deser_frame_unpacker

Overview:
- Downstream neighbour of the deserializer.
- Captures the parallel frame the deserializer produces when its done pulse fires.
- Emits the frame one sample per beat over a valid/ready stream, in sample order, with a last marker and per-sample width masking.
- Decouples the deserializer's frame-at-once output from word-oriented consumers (FEC decoder input, register FIFO) and flags frames lost while draining.

Parameters:
- DATA_WIDTH, 32, bits per sample; matches deserializer DATA_WIDTH.
- DATA_DEPTH, 4, samples per frame buffer; matches deserializer DATA_DEPTH.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- des_done  input  1  deserializer done; one-cycle pulse, frame valid the same cycle
- des_par_out  input  DATA_DEPTH x DATA_WIDTH  deserializer frame; sample k = des_par_out[k]
- des_width  input  $clog2(DATA_WIDTH)+1  index of last valid bit (width minus 1, inclusive)
- des_depth  input  $clog2(DATA_DEPTH)+1  index of last valid sample (depth minus 1, inclusive)
- m_valid  output  1  stream data valid
- m_ready  input  1  stream consumer ready
- m_data  output  DATA_WIDTH  current sample, bits above des_width forced to 0
- m_last  output  1  current beat is the final sample of the frame
- m_index  output  $clog2(DATA_DEPTH)+1  index of current sample
- busy  output  1  frame held or draining
- overflow  output  1  sticky; a frame was dropped
- clr_overflow  input  1  synchronous clear of overflow

Behaviour:
- Reset values: m_valid=0, m_data=0, m_last=0, m_index=0, busy=0, overflow=0.
- Reset also clears the frame buffer, depth_r, mask_r, the edge register and the state (IDLE).
- Reset mid-drain abandons the frame; no beat is emitted after reset release until a new capture.
- Capture event:
  - cap = des_done & ~done_q, where done_q is des_done registered.
  - A held-high done counts as one event.
- States:
  - IDLE: m_valid=0. On cap: latch des_par_out into frame_r, latch depth_r and mask_r, set idx=0, go to DRAIN.
  - DRAIN: m_valid=1 and busy=1.
    - On handshake (m_valid & m_ready) with idx != depth_r: idx <= idx+1.
    - On handshake with idx == depth_r: go to IDLE, unless a simultaneous cap occurs (see back-to-back).
- Latency: cap at cycle N gives m_valid=1 with sample 0 at cycle N+1. With m_ready held high, one beat per cycle.
- Stream outputs:
  - m_data = frame_r[idx] & mask_r, driven combinationally from registers; no combinational path from inputs to outputs.
  - m_last = (idx == depth_r).
  - m_index = idx.
- Stream stability: while m_valid & ~m_ready, m_data, m_last and m_index hold stable. m_valid never drops without a handshake.
- Depth clamp: depth_r = min(des_depth, DATA_DEPTH-1).
- Width mask: mask_r keeps bits 0..des_width. If des_width >= DATA_WIDTH-1, mask_r is all ones.
- Back-to-back frames: cap in the same cycle as the last handshake is accepted.
  - The new frame is captured, idx=0, the block stays in DRAIN.
  - m_valid stays continuously high; no bubble.
- Overflow:
  - cap in DRAIN, not coinciding with the last handshake, drops the new frame.
  - The current frame continues unchanged and overflow sets.
  - clr_overflow clears overflow next cycle.
  - Simultaneous set and clear: set wins.
- Width rules: idx is sized like m_index; increments never exceed depth_r, so no wrap.

Decomposition:
- Shared package (e.g. deser_pkg): unpack_state_t enum {S_IDLE, S_DRAIN}.
- Same package: width helper constants SAMPLE_IDX_W = $clog2(DATA_DEPTH)+1 and BIT_IDX_W = $clog2(DATA_WIDTH)+1, shared with serializer/deserializer.
- Natural sub-module: width_mask_gen, combinational des_width to mask, with the saturation rule above. Everything else stays in one module.

Test Plan:
- Basic drain: frame {0x11111111, 0x22222222, 0x33333333, 0x44444444}, des_depth=3, des_width=31, m_ready=1 -> beats at N+1..N+4 carry 0x11111111..0x44444444, m_index 0..3, m_last only on beat 4, then m_valid=0, busy=0.
- Width mask and depth: des_width=7, des_depth=1, samples 0xDEADBEEF and 0xCAFEF00D -> two beats, 0x000000EF then 0x0000000D, m_last on the second.
- Backpressure: m_ready low for 5 cycles at beat 2 -> m_data=0x22222222 and m_index=1 stable for all 5 cycles; no sample skipped or repeated after release.
- Overflow: second des_done during beat 1 of 4 -> first frame completes intact, second dropped, overflow=1. Pulse clr_overflow -> 0. Coincident set and clear -> overflow=1.
- Back-to-back: cap coincident with the last handshake -> m_valid stays 1 and the next beat is new-frame sample 0 with m_index=0. Also, des_done held high 3 cycles -> exactly one frame captured.
- Reset mid-drain: assert rst_n=0 after beat 2 -> all outputs 0 asynchronously; after release, no beats until a new des_done; depth clamp des_depth=7 -> exactly 4 beats.
